// File: rtl/integer_emitter.sv
// ============================================================================
// integer_emitter: binary integer to decimal ASCII stream (MSD first, ' ' end).
// Optional signed mode: define INTEGER_EMITTER_SIGN_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module integer_emitter #(
    parameter int VALUE_WIDTH = 16,
    parameter int MAX_DIGITS  = 5,
    parameter int CHAR_WIDTH  = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   state_enable,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   char_ready,
    output logic [CHAR_WIDTH-1:0]  char,
    output logic                   char_valid,
    output logic                   has_finished,
    output logic                   busy
);

    localparam int BCD_W   = 4 * MAX_DIGITS;
    localparam int IDX_W   = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int COUNT_W = $clog2(VALUE_WIDTH + 1);

    localparam logic [CHAR_WIDTH-1:0] DIGIT_BASE = CHAR_WIDTH'(8'h30);
    localparam logic [CHAR_WIDTH-1:0] SPACE_CHAR = CHAR_WIDTH'(8'h20);
    localparam logic [CHAR_WIDTH-1:0] MINUS_CHAR = CHAR_WIDTH'(8'h2D);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONVERT = 3'd1,
        S_EMIT    = 3'd2,
        S_TERM    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  state, state_nx;
    logic [VALUE_WIDTH-1:0]  shift_reg, shift_nx;
    logic [BCD_W-1:0]        bcd, bcd_nx;
    logic [COUNT_W-1:0]      count, count_nx;
    logic [IDX_W-1:0]        idx, idx_nx;
    logic                    neg, neg_nx;
    logic [CHAR_WIDTH-1:0]   char_nx;
    logic                    valid_nx;
    logic                    finished_nx;

    logic [BCD_W-1:0]        bcd_adj;
    logic [IDX_W-1:0]        msb_idx;
    logic [IDX_W-1:0]        idx_dec;
    logic [3:0]              cur_nib, msb_nib, next_nib;
    logic                    capture_neg;
    logic [VALUE_WIDTH-1:0]  capture_mag;
    logic                    transfer;

    function automatic logic [CHAR_WIDTH-1:0] digit_char(input logic [3:0] d);
        return DIGIT_BASE + CHAR_WIDTH'(d);
    endfunction

`ifdef INTEGER_EMITTER_SIGN_EN
    // Magnitude taken as unsigned so the most negative value is representable.
    assign capture_neg = value[VALUE_WIDTH-1];
    assign capture_mag = capture_neg ? (~value + VALUE_WIDTH'(1)) : value;
`else
    assign capture_neg = 1'b0;
    assign capture_mag = value;
`endif

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Highest nonzero nibble; an all-zero buffer yields index 0 so a lone '0' is emitted.
    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                msb_idx = IDX_W'(i);
            end
        end
    end

    assign idx_dec  = idx - IDX_W'(1);
    assign cur_nib  = bcd[int'(idx) * 4 +: 4];
    assign msb_nib  = bcd[int'(msb_idx) * 4 +: 4];
    assign next_nib = bcd[int'(idx_dec) * 4 +: 4];
    assign transfer = char_valid && char_ready;
    assign busy     = (state == S_CONVERT) || (state == S_EMIT) || (state == S_TERM);

    always_comb begin
        state_nx    = state;
        shift_nx    = shift_reg;
        bcd_nx      = bcd;
        count_nx    = count;
        idx_nx      = idx;
        neg_nx      = neg;
        char_nx     = char;
        valid_nx    = char_valid;
        finished_nx = has_finished;

        if (!state_enable) begin
            // Abort wins over any simultaneous transfer.
            state_nx    = S_IDLE;
            char_nx     = '0;
            valid_nx    = 1'b0;
            finished_nx = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    shift_nx = capture_mag;
                    neg_nx   = capture_neg;
                    bcd_nx   = '0;
                    count_nx = COUNT_W'(VALUE_WIDTH);
                    state_nx = S_CONVERT;
                end
                S_CONVERT: begin
                    if (count == '0) begin
                        state_nx = S_EMIT;
                        idx_nx   = msb_idx;
                        valid_nx = 1'b1;
                        char_nx  = neg ? MINUS_CHAR : digit_char(msb_nib);
                    end else begin
                        bcd_nx   = {bcd_adj[BCD_W-2:0], shift_reg[VALUE_WIDTH-1]};
                        shift_nx = {shift_reg[VALUE_WIDTH-2:0], 1'b0};
                        count_nx = count - COUNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (transfer) begin
                        if (neg) begin
                            neg_nx  = 1'b0;
                            char_nx = digit_char(cur_nib);
                        end else if (idx == '0) begin
                            state_nx = S_TERM;
                            char_nx  = SPACE_CHAR;
                        end else begin
                            idx_nx  = idx_dec;
                            char_nx = digit_char(next_nib);
                        end
                    end
                end
                S_TERM: begin
                    if (transfer) begin
                        state_nx    = S_DONE;
                        char_nx     = '0;
                        valid_nx    = 1'b0;
                        finished_nx = 1'b1;
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx    = S_IDLE;
                    char_nx     = '0;
                    valid_nx    = 1'b0;
                    finished_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            shift_reg    <= '0;
            bcd          <= '0;
            count        <= '0;
            idx          <= '0;
            neg          <= 1'b0;
            char         <= '0;
            char_valid   <= 1'b0;
            has_finished <= 1'b0;
        end else begin
            state        <= state_nx;
            shift_reg    <= shift_nx;
            bcd          <= bcd_nx;
            count        <= count_nx;
            idx          <= idx_nx;
            neg          <= neg_nx;
            char         <= char_nx;
            char_valid   <= valid_nx;
            has_finished <= finished_nx;
        end
    end

endmodule

`default_nettype wire
